// File: rtl/psum_accum_relu.sv
// psum_accum_relu: accumulates per-pixel psum vectors across kernel positions,
// applies ReLU, and streams the finished activations out.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            one-cycle pulse; latches num_kij/num_nij and begins a tile
//   num_kij          kernel positions per tile (1..9)
//   num_nij          output pixels per tile (1..nij_max)
//   in_valid/in_data incoming signed psum vector, lane i at [i*psum_bw +: psum_bw]
//   out_ready        downstream accepts out_data
//   out_valid        out_data holds a final ReLU'd vector
//   out_data         ReLU'd accumulated vector, same lane packing as in_data
//   busy             high while accumulating or draining
//   done             one-cycle pulse after the last vector has been accepted
//   err              sticky protocol-violation flag
module psum_accum_relu #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned nij_max = 64,
    parameter int unsigned aw      = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               num_kij,
    input  logic [aw:0]              num_nij,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned VecW = col * psum_bw;
    localparam logic [aw:0]   NijMax  = (aw + 1)'(nij_max);
    localparam logic [aw:0]   NijOne  = 1;
    localparam logic [aw-1:0] CntOne  = 1;
    localparam logic [psum_bw-1:0] SatMax = {1'b0, {(psum_bw - 1){1'b1}}};
    localparam logic [psum_bw-1:0] SatMin = {1'b1, {(psum_bw - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [aw-1:0]   nij_cnt_q, nij_cnt_d;
    logic [3:0]      kij_cnt_q, kij_cnt_d;
    logic [3:0]      num_kij_q, num_kij_d;
    logic [aw:0]     num_nij_q, num_nij_d;
    logic            err_q, err_d;

    // Accumulation buffer; not reset because the first kernel pass overwrites it.
    logic [VecW-1:0] mem_q [nij_max];

    logic [VecW-1:0] rd_vec, sat_vec, relu_vec, wr_vec;
    logic            wr_en, args_ok, last_nij, last_kij;

    assign rd_vec   = mem_q[nij_cnt_q];
    assign args_ok  = (num_kij != 4'd0) && (num_kij <= 4'd9) &&
                      (num_nij != '0) && (num_nij <= NijMax);
    assign last_nij = ({1'b0, nij_cnt_q} == (num_nij_q - NijOne));
    assign last_kij = (kij_cnt_q == (num_kij_q - 4'd1));

    // Per-lane saturating add and ReLU on the entry addressed by nij_cnt.
    for (genvar i = 0; i < col; i++) begin : g_lane
        logic [psum_bw-1:0] mem_lane, in_lane;
        logic [psum_bw:0]   sum;

        assign mem_lane = rd_vec[i*psum_bw +: psum_bw];
        assign in_lane  = in_data[i*psum_bw +: psum_bw];
        assign sum      = {mem_lane[psum_bw-1], mem_lane} + {in_lane[psum_bw-1], in_lane};
        // Overflow when the two top bits of the sign-extended sum disagree.
        assign sat_vec[i*psum_bw +: psum_bw] =
            (sum[psum_bw] ^ sum[psum_bw-1]) ? (sum[psum_bw] ? SatMin : SatMax)
                                            : sum[psum_bw-1:0];
        assign relu_vec[i*psum_bw +: psum_bw] = mem_lane[psum_bw-1] ? '0 : mem_lane;
    end

    // First kernel position writes the raw psum so stale data never leaks in.
    assign wr_vec = (kij_cnt_q == 4'd0) ? in_data : sat_vec;

    always_comb begin
        state_d   = state_q;
        nij_cnt_d = nij_cnt_q;
        kij_cnt_d = kij_cnt_q;
        num_kij_d = num_kij_q;
        num_nij_d = num_nij_q;
        err_d     = err_q;
        wr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (args_ok) begin
                        num_kij_d = num_kij;
                        num_nij_d = num_nij;
                        nij_cnt_d = '0;
                        kij_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = StAccum;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (in_valid) err_d = 1'b1;
            end
            StAccum: begin
                if (start) err_d = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (last_nij) begin
                        nij_cnt_d = '0;
                        if (last_kij) state_d = StDrain;
                        else          kij_cnt_d = kij_cnt_q + 4'd1;
                    end else begin
                        nij_cnt_d = nij_cnt_q + CntOne;
                    end
                end
            end
            StDrain: begin
                if (start || in_valid) err_d = 1'b1;
                if (out_ready) begin
                    if (last_nij) begin
                        nij_cnt_d = '0;
                        state_d   = StDone;
                    end else begin
                        nij_cnt_d = nij_cnt_q + CntOne;
                    end
                end
            end
            StDone: begin
                if (start || in_valid) err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            nij_cnt_q <= '0;
            kij_cnt_q <= '0;
            num_kij_q <= '0;
            num_nij_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nij_cnt_q <= nij_cnt_d;
            kij_cnt_q <= kij_cnt_d;
            num_kij_q <= num_kij_d;
            num_nij_q <= num_nij_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[nij_cnt_q] <= wr_vec;
    end

    // Output is a direct view of the buffer; it cannot change while stalled
    // because nothing writes the buffer outside ACCUM.
    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? relu_vec : '0;
    assign busy      = (state_q == StAccum) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule
